// File: rtl/mopshub_test_sequencer_if.sv
// Handshake bundle between the MOPSHUB top, the test sequencer and the data generator.
//   master : start/abort/config and generator end pulses into the sequencer
//   slave  : the sequencer itself (phase requests, bus select, status, counters out)
interface mopshub_test_sequencer_if #(
  parameter int unsigned BUS_W = 5
);
  // control from the MOPSHUB top
  logic             sign_on_sig;
  logic             abort;
  logic [BUS_W-1:0] n_buses;
  logic             enable_rx;
  logic             enable_tx;
  // completion pulses from data_generator
  logic             test_rx_end;
  logic             test_tx_end;
  logic             costum_msg_end;
  // phase requests to data_generator
  logic             test_rx;
  logic             test_tx;
  logic             test_advanced;
  logic             endwait_all;
  logic [BUS_W-1:0] bus_sel;
  // status and accounting
  logic             busy;
  logic             done;
  logic             timeout_flag;
  logic [15:0]      pass_cnt;
  logic [15:0]      fail_cnt;
  logic [15:0]      loop_cnt;

  modport master (
    output sign_on_sig, abort, n_buses, enable_rx, enable_tx,
    output test_rx_end, test_tx_end, costum_msg_end,
    input  test_rx, test_tx, test_advanced, endwait_all, bus_sel,
    input  busy, done, timeout_flag, pass_cnt, fail_cnt, loop_cnt
  );

  modport slave (
    input  sign_on_sig, abort, n_buses, enable_rx, enable_tx,
    input  test_rx_end, test_tx_end, costum_msg_end,
    output test_rx, test_tx, test_advanced, endwait_all, bus_sel,
    output busy, done, timeout_flag, pass_cnt, fail_cnt, loop_cnt
  );
endinterface

// File: rtl/mopshub_test_sequencer.sv
// MOPSHUB data-generator test sequencer: walks RX / TX (and optionally custom-message)
// test phases over every active CAN bus, with per-phase timeout, loop control and
// saturating pass/fail accounting.
// Ports:
//   clk  : system clock (40 MHz domain)
//   rst  : asynchronous active-low reset
//   bus  : mopshub_test_sequencer_if.slave (start/abort/config in, end pulses in,
//          phase requests, bus_sel, busy/done/timeout_flag, pass/fail/loop counters out)
// Optional feature: define MOPSHUB_SEQ_ADVANCED_EN to compile in the custom-message (ADV)
// phase driven by test_advanced / costum_msg_end.
module mopshub_test_sequencer #(
  parameter int unsigned     N_BUSES    = 16,
  parameter int unsigned     BUS_W      = 5,
  parameter int unsigned     TO_W       = 24,
  parameter logic [TO_W-1:0] TIMEOUT    = TO_W'(2000000),
  parameter int unsigned     GAP_CYCLES = 120,
  parameter int unsigned     N_LOOPS    = 0
) (
  input logic                    clk,
  input logic                    rst,
  mopshub_test_sequencer_if.slave bus
);

  localparam int unsigned     GAP_W    = $clog2(GAP_CYCLES + 1) + 1;
  localparam int unsigned     TOX_W    = TO_W + 1;
  localparam logic [BUS_W-1:0] LAST_MAX = BUS_W'(N_BUSES - 1);
  localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_ENDW,
    ST_GAP,
    ST_TX,
`ifdef MOPSHUB_SEQ_ADVANCED_EN
    ST_ADV,
`endif
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic             test_rx_q;
  logic             test_tx_q;
  logic             endwait_q;
  logic [BUS_W-1:0] bus_sel_q;
  logic             busy_q;
  logic             done_q;
  logic             tflag_q;
  logic [15:0]      pass_cnt_q;
  logic [15:0]      fail_cnt_q;
  logic [15:0]      loop_cnt_q;
  logic             en_rx_q;
  logic             en_tx_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
`ifdef MOPSHUB_SEQ_ADVANCED_EN
  logic             test_adv_q;
`else
  logic             unused_costum_d;
  assign unused_costum_d = bus.costum_msg_end;
`endif

  logic [BUS_W-1:0] last_bus_d;
  logic [15:0]      pass_inc_d;
  logic [15:0]      fail_inc_d;
  logic [15:0]      loop_inc_d;
  logic             loop_last_d;
  logic             to_expire_d;
  logic             in_phase_d;
  logic             phase_end_d;
  logic             phase_exit_d;

  // Runtime bus count, clamped to the physical bus range
  assign last_bus_d  = (bus.n_buses > LAST_MAX) ? LAST_MAX : bus.n_buses;

  assign pass_inc_d  = (pass_cnt_q == CNT_MAX) ? pass_cnt_q : pass_cnt_q + 16'd1;
  assign fail_inc_d  = (fail_cnt_q == CNT_MAX) ? fail_cnt_q : fail_cnt_q + 16'd1;
  assign loop_inc_d  = (loop_cnt_q == CNT_MAX) ? loop_cnt_q : loop_cnt_q + 16'd1;
  assign loop_last_d = (N_LOOPS != 0) && (32'(loop_inc_d) >= N_LOOPS);

  // to_cnt_q holds (cycles already spent in the phase); expiry on the TIMEOUT-th cycle
  assign to_expire_d = (TOX_W'(to_cnt_q) + TOX_W'(1)) >= TOX_W'(TIMEOUT);

  // Select the end pulse belonging to the phase currently requested
  always_comb begin
    in_phase_d  = 1'b0;
    phase_end_d = 1'b0;
    case (state_q)
      ST_RX: begin
        in_phase_d  = 1'b1;
        phase_end_d = bus.test_rx_end;
      end
      ST_TX: begin
        in_phase_d  = 1'b1;
        phase_end_d = bus.test_tx_end;
      end
`ifdef MOPSHUB_SEQ_ADVANCED_EN
      ST_ADV: begin
        in_phase_d  = 1'b1;
        phase_end_d = bus.costum_msg_end;
      end
`endif
      default: ;
    endcase
  end

  // End pulse wins over a simultaneous expiry
  assign phase_exit_d = in_phase_d && (phase_end_d || to_expire_d);

  // Sequencer state machine with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      test_rx_q  <= 1'b0;
      test_tx_q  <= 1'b0;
      endwait_q  <= 1'b0;
      bus_sel_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tflag_q    <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      loop_cnt_q <= '0;
      en_rx_q    <= 1'b0;
      en_tx_q    <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
`ifdef MOPSHUB_SEQ_ADVANCED_EN
      test_adv_q <= 1'b0;
`endif
    end else if (bus.abort) begin
      // Abort overrides everything; counters and bus_sel are kept for inspection
      state_q    <= ST_IDLE;
      test_rx_q  <= 1'b0;
      test_tx_q  <= 1'b0;
      endwait_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
`ifdef MOPSHUB_SEQ_ADVANCED_EN
      test_adv_q <= 1'b0;
`endif
    end else begin
      endwait_q <= 1'b0;

      // Phase timer and pass/fail accounting shared by all request phases
      if (in_phase_d && !phase_exit_d) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if (phase_exit_d) begin
        if (phase_end_d) begin
          pass_cnt_q <= pass_inc_d;
        end else begin
          fail_cnt_q <= fail_inc_d;
          tflag_q    <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.sign_on_sig && (bus.enable_rx || bus.enable_tx)) begin
            en_rx_q    <= bus.enable_rx;
            en_tx_q    <= bus.enable_tx;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            loop_cnt_q <= '0;
            tflag_q    <= 1'b0;
            bus_sel_q  <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            if (bus.enable_rx) begin
              state_q   <= ST_RX;
              test_rx_q <= 1'b1;
            end else begin
              state_q   <= ST_TX;
              test_tx_q <= 1'b1;
            end
          end
        end

        ST_RX: begin
          if (phase_exit_d) begin
            state_q   <= ST_ENDW;
            test_rx_q <= 1'b0;
            endwait_q <= 1'b1;
          end
        end

        ST_ENDW: begin
          state_q   <= ST_GAP;
          gap_cnt_q <= '0;
        end

        // GAP_CYCLES+1 cycles here so TX rises GAP_CYCLES+1 after endwait_all falls
        ST_GAP: begin
          if (32'(gap_cnt_q) >= GAP_CYCLES) begin
            if (en_tx_q) begin
              state_q   <= ST_TX;
              test_tx_q <= 1'b1;
            end else begin
`ifdef MOPSHUB_SEQ_ADVANCED_EN
              state_q    <= ST_ADV;
              test_adv_q <= 1'b1;
`else
              state_q    <= ST_NEXT;
`endif
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end

        ST_TX: begin
          if (phase_exit_d) begin
            test_tx_q <= 1'b0;
`ifdef MOPSHUB_SEQ_ADVANCED_EN
            state_q    <= ST_ADV;
            test_adv_q <= 1'b1;
`else
            state_q    <= ST_NEXT;
`endif
          end
        end

`ifdef MOPSHUB_SEQ_ADVANCED_EN
        ST_ADV: begin
          if (phase_exit_d) begin
            state_q    <= ST_NEXT;
            test_adv_q <= 1'b0;
          end
        end
`endif

        // Advance or wrap the bus index, then re-enter the first enabled phase
        ST_NEXT: begin
          if (bus_sel_q >= last_bus_d) begin
            bus_sel_q  <= '0;
            loop_cnt_q <= loop_inc_d;
          end else begin
            bus_sel_q  <= bus_sel_q + BUS_W'(1);
          end
          if ((bus_sel_q >= last_bus_d) && loop_last_d) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (en_rx_q) begin
            state_q   <= ST_RX;
            test_rx_q <= 1'b1;
          end else begin
            state_q   <= ST_TX;
            test_tx_q <= 1'b1;
          end
        end

        ST_DONE: ;

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.test_rx      = test_rx_q;
  assign bus.test_tx      = test_tx_q;
`ifdef MOPSHUB_SEQ_ADVANCED_EN
  assign bus.test_advanced = test_adv_q;
`else
  assign bus.test_advanced = 1'b0;
`endif
  assign bus.endwait_all  = endwait_q;
  assign bus.bus_sel      = bus_sel_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.pass_cnt     = pass_cnt_q;
  assign bus.fail_cnt     = fail_cnt_q;
  assign bus.loop_cnt     = loop_cnt_q;

endmodule
